// File: rtl/trig_scaler_pkg.sv
// Shared constants, read-map addresses and FSM state type for the per-SURF trigger scaler.
package trig_scaler_pkg;

  localparam int          NSURF_REAL   = 28;
  localparam logic [5:0]  ADR_STATUS   = 6'd28;
  localparam logic [5:0]  ADR_DEADTIME = 6'd29;
  localparam logic [5:0]  ADR_ID       = 6'd31;
  localparam logic [15:0] SCAL_ID      = 16'h5343;

  typedef enum logic {
    COUNT,
    DUMP
  } state_t;

endpackage

// File: rtl/trig_scaler_gate.sv
// Gate-window generator: PPS rising edge or internal period timer, producing a registered gate_end.
module trig_scaler_gate (
  input  logic        clk,
  input  logic        rst,
  input  logic        pps,
  input  logic        gate_sel,
  input  logic [31:0] period,
  output logic        gate_end
);

  logic        pps_q;
  logic        sel_q;
  logic [31:0] timer;
  logic        sel_change;
  logic        tick;
  logic        gate_next;

  // >= rather than == so a period lowered below the running timer still ends the window
  always_comb begin
    sel_change = (gate_sel != sel_q);
    tick       = !gate_sel && (period != '0) && (timer >= period - 32'd1);
    gate_next  = 1'b0;
    if (!sel_change) begin
      gate_next = gate_sel ? (pps && !pps_q) : tick;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pps_q    <= 1'b0;
      sel_q    <= 1'b0;
      timer    <= '0;
      gate_end <= 1'b0;
    end else begin
      pps_q    <= pps;
      sel_q    <= gate_sel;
      gate_end <= gate_next;
      if (sel_change || gate_sel || (period == '0) || tick) begin
        timer <= '0;
      end else begin
        timer <= timer + 32'd1;
      end
    end
  end

endmodule

// File: rtl/trig_surf_scaler.sv
// Per-SURF trigger-rate scaler: gated saturating counters, snapshot bank and registered read port.
// Optional busy dead-time counter at address 29 when TRIG_SCALER_DEADTIME_EN is defined.
module trig_surf_scaler
  import trig_scaler_pkg::*;
#(
  parameter int NSURF     = NSURF_REAL,
  parameter int CNT_WIDTH = 16
) (
  input  logic                sysclk_i,
  input  logic                sysclk_rst_i,
  input  logic [NSURF*16-1:0] trigin_dat_i,
  input  logic                trigin_valid_i,
  input  logic [NSURF-1:0]    trig_mask_i,
  input  logic                pps_i,
  input  logic                gate_sel_i,
  input  logic [31:0]         period_i,
`ifdef TRIG_SCALER_DEADTIME_EN
  input  logic                busy_i,
`endif
  input  logic [5:0]          scal_adr_i,
  output logic [31:0]         scal_dat_o,
  output logic                scal_update_o,
  output logic [15:0]         scal_seq_o
);

`ifdef TRIG_SCALER_DEADTIME_EN
  localparam int NDUMP = NSURF + 1;
`else
  localparam int NDUMP = NSURF;
`endif
  localparam int IW = $clog2(NDUMP);

  logic [NSURF-1:0]     hit;
  logic [CNT_WIDTH-1:0] cnt  [NSURF];
  logic [CNT_WIDTH-1:0] hold [NSURF];
  logic [CNT_WIDTH-1:0] bank [NSURF];
  logic                 gate_end;
  state_t               state;
  state_t               state_next;
  logic [IW-1:0]        idx;
  logic                 dump_we;
  logic                 dump_last;
  logic                 overrun;
  logic                 lost;
  logic [31:0]          dt_word;
  logic [31:0]          rd;
  logic                 dat_unused;

  assign dat_unused = ^trigin_dat_i;

  trig_scaler_gate u_gate (
    .clk      (sysclk_i),
    .rst      (sysclk_rst_i),
    .pps      (pps_i),
    .gate_sel (gate_sel_i),
    .period   (period_i),
    .gate_end (gate_end)
  );

  always_ff @(posedge sysclk_i or posedge sysclk_rst_i) begin
    if (sysclk_rst_i) begin
      hit <= '0;
    end else begin
      for (int unsigned k = 0; k < NSURF; k++) begin
        hit[k] <= trigin_valid_i && trigin_dat_i[16*k+15] && !trig_mask_i[k];
      end
    end
  end

  // Hold is frozen while a dump is reading it; the counters still restart the window.
  always_ff @(posedge sysclk_i or posedge sysclk_rst_i) begin
    if (sysclk_rst_i) begin
      for (int unsigned k = 0; k < NSURF; k++) begin
        cnt[k]  <= '0;
        hold[k] <= '0;
      end
    end else begin
      for (int unsigned k = 0; k < NSURF; k++) begin
        if (gate_end) begin
          if (state == COUNT) hold[k] <= cnt[k];
          cnt[k] <= CNT_WIDTH'(hit[k]);
        end else if (hit[k] && (cnt[k] != '1)) begin
          cnt[k] <= cnt[k] + CNT_WIDTH'(1);
        end
      end
    end
  end

  always_ff @(posedge sysclk_i or posedge sysclk_rst_i) begin
    if (sysclk_rst_i) state <= COUNT;
    else              state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      COUNT:   if (gate_end)  state_next = DUMP;
      DUMP:    if (dump_last) state_next = COUNT;
      default: state_next = COUNT;
    endcase
  end

  always_comb begin
    dump_we   = (state == DUMP);
    dump_last = dump_we && (idx == IW'(NDUMP - 1));
  end

  always_ff @(posedge sysclk_i or posedge sysclk_rst_i) begin
    if (sysclk_rst_i) begin
      idx <= '0;
    end else if (dump_we && !dump_last) begin
      idx <= idx + IW'(1);
    end else begin
      idx <= '0;
    end
  end

  always_ff @(posedge sysclk_i or posedge sysclk_rst_i) begin
    if (sysclk_rst_i) begin
      for (int unsigned k = 0; k < NSURF; k++) bank[k] <= '0;
    end else if (dump_we) begin
      for (int unsigned k = 0; k < NSURF; k++) begin
        if (idx == IW'(k)) bank[k] <= hold[k];
      end
    end
  end

  always_ff @(posedge sysclk_i or posedge sysclk_rst_i) begin
    if (sysclk_rst_i) begin
      scal_update_o <= 1'b0;
      scal_seq_o    <= '0;
      overrun       <= 1'b0;
      lost          <= 1'b0;
    end else begin
      scal_update_o <= dump_last;
      if (dump_last) scal_seq_o <= scal_seq_o + 16'd1;
      if (dump_we && gate_end)         overrun <= 1'b1;
      else if (dump_last && !lost)     overrun <= 1'b0;
      if (dump_last)                   lost <= 1'b0;
      else if (dump_we && gate_end)    lost <= 1'b1;
    end
  end

`ifdef TRIG_SCALER_DEADTIME_EN
  logic [31:0] dt_cnt;
  logic [31:0] dt_hold;
  logic [31:0] dt_bank;

  always_ff @(posedge sysclk_i or posedge sysclk_rst_i) begin
    if (sysclk_rst_i) begin
      dt_cnt  <= '0;
      dt_hold <= '0;
      dt_bank <= '0;
    end else begin
      if (gate_end) begin
        if (state == COUNT) dt_hold <= dt_cnt;
        dt_cnt <= {31'b0, busy_i};
      end else if (busy_i && (dt_cnt != '1)) begin
        dt_cnt <= dt_cnt + 32'd1;
      end
      if (dump_we && (idx == IW'(NSURF))) dt_bank <= dt_hold;
    end
  end

  assign dt_word = dt_bank;
`else
  assign dt_word = '0;
`endif

  always_comb begin
    rd = '0;
    for (int unsigned k = 0; k < NSURF; k++) begin
      if (scal_adr_i == 6'(k)) rd = 32'(bank[k]);
    end
    if (scal_adr_i == ADR_STATUS)   rd = {overrun, 15'b0, scal_seq_o};
    if (scal_adr_i == ADR_DEADTIME) rd = dt_word;
    if (scal_adr_i == ADR_ID)       rd = {SCAL_ID, 8'(CNT_WIDTH), 8'(NSURF)};
  end

  always_ff @(posedge sysclk_i or posedge sysclk_rst_i) begin
    if (sysclk_rst_i) scal_dat_o <= '0;
    else              scal_dat_o <= rd;
  end

endmodule

// File: tb/tb_trig_surf_scaler.sv
// Self-checking bench for trig_surf_scaler: read scoreboard, vector tables and gate/overrun/reset sequences.
module tb_trig_surf_scaler;

  localparam int          NS   = 28;
  localparam logic [31:0] ID16 = 32'h5343_101C;
  localparam logic [31:0] ID8  = 32'h5343_081C;

  logic              clk      = 1'b0;
  logic              rst      = 1'b1;
  logic [NS*16-1:0]  dat      = '0;
  logic              valid    = 1'b0;
  logic [NS-1:0]     mask     = '0;
  logic              pps      = 1'b0;
  logic              gate_sel = 1'b0;
  logic [31:0]       period   = '0;
  logic              busy     = 1'b0;
  logic [5:0]        adr      = '0;
  logic [31:0]       rdat, rdat8;
  logic              upd, upd8;
  logic [15:0]       seq, seq8;

  int          total   = 0;
  int          bad     = 0;
  int          upd_cnt = 0;
  logic [15:0] seq_model = '0;

  typedef struct {
    logic [5:0]  adr;
    logic [31:0] exp;
    logic [31:0] msk;
    bit          on8;
    logic [31:0] exp8;
    string       name;
  } rd_t;

  rd_t sb[$];
  rd_t tbl[$];

  always #5 clk = ~clk;

  trig_surf_scaler #(.NSURF(NS), .CNT_WIDTH(16)) dut (
    .sysclk_i(clk), .sysclk_rst_i(rst), .trigin_dat_i(dat), .trigin_valid_i(valid),
    .trig_mask_i(mask), .pps_i(pps), .gate_sel_i(gate_sel), .period_i(period),
`ifdef TRIG_SCALER_DEADTIME_EN
    .busy_i(busy),
`endif
    .scal_adr_i(adr), .scal_dat_o(rdat), .scal_update_o(upd), .scal_seq_o(seq)
  );

  trig_surf_scaler #(.NSURF(NS), .CNT_WIDTH(8)) dut8 (
    .sysclk_i(clk), .sysclk_rst_i(rst), .trigin_dat_i(dat), .trigin_valid_i(valid),
    .trig_mask_i(mask), .pps_i(pps), .gate_sel_i(gate_sel), .period_i(period),
`ifdef TRIG_SCALER_DEADTIME_EN
    .busy_i(busy),
`endif
    .scal_adr_i(adr), .scal_dat_o(rdat8), .scal_update_o(upd8), .scal_seq_o(seq8)
  );

  always @(negedge clk) begin
    if (rst) seq_model = '0;
    else if (upd) begin
      upd_cnt++;
      seq_model++;
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic add(input logic [5:0] a, input logic [31:0] e, input string n,
                     input logic [31:0] m = '1, input bit o8 = 1'b0, input logic [31:0] e8 = '0);
    rd_t r;
    r.adr = a; r.exp = e; r.msk = m; r.on8 = o8; r.exp8 = e8; r.name = n;
    tbl.push_back(r);
  endtask

  task automatic rd(input rd_t r);
    rd_t e;
    logic [31:0] a;
    adr = r.adr;
    sb.push_back(r);
    cyc();
    e = sb.pop_front();
    a = $isunknown(rdat) ? 'x : (rdat & e.msk);
    check(e.name, a, e.exp & e.msk);
    if (e.on8) begin
      a = $isunknown(rdat8) ? 'x : (rdat8 & e.msk);
      check({e.name, "_w8"}, a, e.exp8 & e.msk);
    end
  endtask

  task automatic run_tbl();
    foreach (tbl[i]) rd(tbl[i]);
    tbl.delete();
  endtask

  // One valid strobe then three idle cycles; idle words carry bit 15 set everywhere.
  task automatic strobe(input logic [NS-1:0] sel);
    for (int k = 0; k < NS; k++) begin
      dat[16*k +: 15] = 15'($urandom);
      dat[16*k+15]    = sel[k];
    end
    valid = 1'b1;
    cyc();
    valid = 1'b0;
    for (int k = 0; k < NS; k++) dat[16*k+15] = 1'b1;
    repeat (3) cyc();
  endtask

  task automatic wait_update(input string name, input int budget);
    int u;
    int n;
    u = upd_cnt;
    n = 0;
    while (upd_cnt == u && n < budget) begin
      cyc();
      n++;
    end
    total++;
    if (upd_cnt == u) begin
      bad++;
      $display("FAIL %s: got 0 update pulses in %0d cycles want 1", name, budget);
    end
  endtask

  initial begin
    logic [NS-1:0] s;
    int u0;

    repeat (4) cyc();
    rst = 1'b0;
    repeat (2) cyc();

    // reset state
    check("rst_seq", 32'(seq), 32'd0);
    check("rst_upd", 32'(upd), 32'd0);
    add(6'd0,  32'd0, "rst_bank0");
    add(6'd3,  32'd0, "rst_bank3");
    add(6'd27, 32'd0, "rst_bank27");
    add(6'd28, 32'd0, "rst_status");
    add(6'd29, 32'd0, "rst_adr29");
    add(6'd31, ID16,  "id", '1, 1'b1, ID8);
    add(6'd63, 32'd0, "rst_adr63");
    run_tbl();

    // basic counting on SURF 3
    s = '0; s[3] = 1'b1;
    u0 = upd_cnt;
    period = 32'd10000;
    repeat (100) strobe(s);
    wait_update("t1_update", 12000);
    period = '0;
    repeat (30) cyc();
    check("t1_upd_once", 32'(upd_cnt - u0), 32'd1);
    add(6'd3,  32'd100, "t1_bank3");
    add(6'd0,  32'd0,   "t1_bank0");
    add(6'd5,  32'd0,   "t1_bank5");
    add(6'd27, 32'd0,   "t1_bank27");
    add(6'd28, 32'd1,   "t1_status");
    run_tbl();

    // mask SURF 3, SURF 5 gets 7 hits
    mask[3] = 1'b1;
    period = 32'd10000;
    for (int i = 0; i < 100; i++) begin
      s = '0; s[3] = 1'b1; s[5] = (i < 7);
      strobe(s);
    end
    wait_update("t2_update", 12000);
    period = '0;
    mask = '0;
    repeat (30) cyc();
    add(6'd3,  32'd0, "t2_bank3_masked");
    add(6'd5,  32'd7, "t2_bank5");
    add(6'd28, 32'd2, "t2_status");
    run_tbl();

    // saturation: 300 hits, 16-bit vs 8-bit instance
    s = '0; s[0] = 1'b1;
    period = 32'd10000;
    repeat (300) strobe(s);
    wait_update("t3_update", 12000);
    period = '0;
    repeat (30) cyc();
    add(6'd0,  32'd300, "t3_bank0", '1, 1'b1, 32'd255);
    add(6'd28, 32'd3,   "t3_status");
    run_tbl();

    // PPS gating, internal period ignored
    gate_sel = 1'b1;
    repeat (5) cyc();
    period = 32'd50;
    u0 = upd_cnt;
    pps = 1'b1;
    repeat (100) cyc();
    pps = 1'b0;
    s = '0; s[7] = 1'b1;
    repeat (20) strobe(s);
    repeat (5000 - 180) cyc();
    pps = 1'b1;
    repeat (100) cyc();
    pps = 1'b0;
    repeat (20) cyc();
    check("t4_two_updates", 32'(upd_cnt - u0), 32'd2);
    add(6'd7,  32'd20, "t4_bank7");
    add(6'd3,  32'd0,  "t4_bank3");
    add(6'd28, 32'd5,  "t4_status");
    run_tbl();
    period = '0;
    gate_sel = 1'b0;
    repeat (5) cyc();

    // overrun with period shorter than the dump
    u0 = upd_cnt;
    period = 32'd20;
    repeat (200) cyc();
    add(6'd28, 32'h8000_0000, "t5_overrun", 32'h8000_0000);
    add(6'd0,  32'd0,         "t5_no_x",    32'd0);
    run_tbl();
    check("t5_dumps_done", 32'((upd_cnt - u0) >= 3), 32'd1);
    period = 32'd1000;
    repeat (50) cyc();
    wait_update("t5_recover_update", 2000);
    period = '0;
    repeat (5) cyc();
    add(6'd28, {16'h0, seq_model}, "t5_overrun_clear");
    run_tbl();

    // reset in the middle of a dump
    gate_sel = 1'b1;
    repeat (5) cyc();
    s = '0; s[2] = 1'b1;
    repeat (10) strobe(s);
    u0 = upd_cnt;
    pps = 1'b1;
    repeat (11) cyc();
    rst = 1'b1;
    pps = 1'b0;
    repeat (3) cyc();
    rst = 1'b0;
    repeat (40) cyc();
    check("t6_no_update", 32'(upd_cnt - u0), 32'd0);
    check("t6_seq", 32'(seq), 32'd0);
    for (int a = 0; a < 64; a++) begin
      add(6'(a), (a == 31) ? ID16 : 32'd0, $sformatf("t6_adr%0d", a));
    end
    run_tbl();
    pps = 1'b1;
    wait_update("t6_post_update", 200);
    pps = 1'b0;
    repeat (30) cyc();
    add(6'd2,  32'd0, "t6_hold_cleared");
    add(6'd28, 32'd1, "t6_status");
    run_tbl();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
